// File: rtl/nfc_page_program_sequencer.sv
// Page-program front-end for the NAND controller: issues way-select, row
// address and program commands, streams the page data, then polls 70h status
// until ready/timeout and returns a single response per request.
module nfc_page_program_sequencer #(
    parameter int NumberOfWays = 2,
    parameter int PollGap      = 16,
    parameter int MaxPolls     = 1024
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic                    iReqValid,
    output logic                    oReqReady,
    input  logic [NumberOfWays-1:0] iReqWay,
    input  logic [23:0]             iReqRow,
    input  logic [15:0]             iReqLength,
    input  logic                    iReqCache,
    output logic                    oRspValid,
    input  logic                    iRspReady,
    output logic                    oRspFail,
    output logic                    oRspTimeout,
    output logic [7:0]              oRspStatus,
    input  logic [15:0]             iUsrWriteData,
    input  logic [1:0]              iUsrWriteKeep,
    input  logic                    iUsrWriteLast,
    input  logic                    iUsrWriteValid,
    output logic                    oUsrWriteReady,
    output logic [5:0]              oOpcode,
    output logic [4:0]              oTargetID,
    output logic [4:0]              oSourceID,
    output logic [31:0]             oAddress,
    output logic [15:0]             oLength,
    output logic                    oCMDValid,
    input  logic                    iCMDReady,
    output logic [15:0]             oWriteData,
    output logic [1:0]              oWriteKeep,
    output logic                    oWriteLast,
    output logic                    oWriteValid,
    input  logic                    iWriteReady,
    input  logic [15:0]             iReadData,
    input  logic                    iReadValid,
    input  logic                    iReadLast,
    output logic                    oReadReady
);

    typedef enum logic [3:0] {
        S_IDLE, S_WAY, S_ROW, S_PROG, S_WDATA,
        S_STAT_CMD, S_STAT_RD, S_EVAL, S_GAP, S_RESP
    } state_t;

    state_t                  r_state, w_next;
    logic [NumberOfWays-1:0] r_way;
    logic [23:0]             r_row;
    logic [15:0]             r_len;
    logic                    r_cache;
    logic [7:0]              r_status;
    logic [15:0]             r_polls;
    logic [15:0]             r_gap;
    logic                    r_first;
    logic                    w_done;
    logic                    w_out_of_polls;
    logic                    w_unused;

    // Cache programs wait for RDY (bit6), plain programs for ARDY (bit5).
    assign w_done         = r_cache ? r_status[6] : r_status[5];
    assign w_out_of_polls = (r_polls >= 16'(MaxPolls));
    assign w_unused       = ^iReadData[15:8];

    // State register.
    always_ff @(posedge iSystemClock) begin
        if (iReset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and command/stream outputs.
    always_comb begin
        w_next         = r_state;
        oReqReady      = (r_state == S_IDLE);
        oRspValid      = (r_state == S_RESP);
        oCMDValid      = 1'b0;
        oOpcode        = '0;
        oTargetID      = '0;
        oSourceID      = '0;
        oAddress       = '0;
        oLength        = '0;
        oWriteData     = iUsrWriteData;
        oWriteKeep     = iUsrWriteKeep;
        oWriteLast     = iUsrWriteLast;
        oWriteValid    = 1'b0;
        oUsrWriteReady = 1'b0;
        oReadReady     = 1'b0;
        case (r_state)
            S_IDLE: if (iReqValid) w_next = S_WAY;
            S_WAY: begin
                oCMDValid = 1'b1;
                oOpcode   = 6'b100000;
                oAddress  = 32'(r_way);
                oLength   = 16'd8;
                if (iCMDReady) w_next = S_ROW;
            end
            S_ROW: begin
                oCMDValid = 1'b1;
                oOpcode   = 6'b100100;
                oAddress  = {8'd0, r_row};
                oLength   = 16'd8;
                if (iCMDReady) w_next = S_PROG;
            end
            S_PROG: begin
                oCMDValid = 1'b1;
                oOpcode   = 6'b000011;
                oTargetID = {4'd0, r_cache};
                oLength   = r_len;
                if (iCMDReady) w_next = S_WDATA;
            end
            S_WDATA: begin
                oWriteValid    = iUsrWriteValid;
                oUsrWriteReady = iWriteReady;
                if (iUsrWriteValid && iWriteReady && iUsrWriteLast) w_next = S_STAT_CMD;
            end
            S_STAT_CMD: begin
                oCMDValid = 1'b1;
                oOpcode   = 6'b000111;
                oTargetID = 5'b00100;
                oLength   = 16'd8;
                if (iCMDReady) w_next = S_STAT_RD;
            end
            S_STAT_RD: begin
                oReadReady = 1'b1;
                if (iReadValid && iReadLast) w_next = S_EVAL;
            end
            S_EVAL: w_next = (w_done || w_out_of_polls) ? S_RESP : S_GAP;
            S_GAP:  if (r_gap >= 16'(PollGap - 1)) w_next = S_STAT_CMD;
            S_RESP: if (iRspReady) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // A reset abandons the request immediately, including any pending command.
        if (iReset) oCMDValid = 1'b0;
    end

    // Request latch, status capture, poll/gap counters and response fields.
    always_ff @(posedge iSystemClock) begin
        if (iReset) begin
            r_way       <= '0;
            r_row       <= '0;
            r_len       <= '0;
            r_cache     <= 1'b0;
            r_status    <= '0;
            r_polls     <= '0;
            r_gap       <= '0;
            r_first     <= 1'b0;
            oRspFail    <= 1'b0;
            oRspTimeout <= 1'b0;
            oRspStatus  <= '0;
        end else begin
            if (r_state == S_IDLE && iReqValid) begin
                r_way   <= iReqWay;
                r_row   <= iReqRow;
                r_len   <= iReqLength;
                r_cache <= iReqCache;
                r_polls <= '0;
            end
            if (r_state == S_STAT_CMD && iCMDReady) r_first <= 1'b1;
            // Only the first beat of a status read carries the status byte.
            if (r_state == S_STAT_RD && iReadValid) begin
                r_first <= 1'b0;
                if (r_first) begin
                    r_status <= iReadData[7:0];
                    if (r_polls != 16'hFFFF) r_polls <= r_polls + 16'd1;
                end
            end
            if (r_state == S_EVAL) begin
                r_gap <= '0;
                if (w_done) begin
                    oRspFail    <= r_status[0];
                    oRspTimeout <= 1'b0;
                    oRspStatus  <= r_status;
                end else if (w_out_of_polls) begin
                    oRspFail    <= 1'b0;
                    oRspTimeout <= 1'b1;
                    oRspStatus  <= r_status;
                end
            end
            if (r_state == S_GAP) r_gap <= r_gap + 16'd1;
        end
    end

endmodule

// File: tb/tb_nfc_page_program_sequencer.sv
// Randomized bench: a behavioural model predicts the command list, write beats
// and response of each request from the status replies the bench feeds back.
module tb_nfc_page_program_sequencer;
    localparam int NW = 2;
    localparam int PG = 5;
    localparam int MP = 3;

    logic          iSystemClock = 1'b0;
    logic          iReset;
    logic          iReqValid, oReqReady;
    logic [NW-1:0] iReqWay;
    logic [23:0]   iReqRow;
    logic [15:0]   iReqLength;
    logic          iReqCache;
    logic          oRspValid, iRspReady, oRspFail, oRspTimeout;
    logic [7:0]    oRspStatus;
    logic [15:0]   iUsrWriteData;
    logic [1:0]    iUsrWriteKeep;
    logic          iUsrWriteLast, iUsrWriteValid, oUsrWriteReady;
    logic [5:0]    oOpcode;
    logic [4:0]    oTargetID, oSourceID;
    logic [31:0]   oAddress;
    logic [15:0]   oLength;
    logic          oCMDValid, iCMDReady;
    logic [15:0]   oWriteData;
    logic [1:0]    oWriteKeep;
    logic          oWriteLast, oWriteValid, iWriteReady;
    logic [15:0]   iReadData;
    logic          iReadValid, iReadLast, oReadReady;

    nfc_page_program_sequencer #(.NumberOfWays(NW), .PollGap(PG), .MaxPolls(MP)) dut (
        .iSystemClock(iSystemClock), .iReset(iReset),
        .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqWay(iReqWay), .iReqRow(iReqRow),
        .iReqLength(iReqLength), .iReqCache(iReqCache),
        .oRspValid(oRspValid), .iRspReady(iRspReady), .oRspFail(oRspFail),
        .oRspTimeout(oRspTimeout), .oRspStatus(oRspStatus),
        .iUsrWriteData(iUsrWriteData), .iUsrWriteKeep(iUsrWriteKeep), .iUsrWriteLast(iUsrWriteLast),
        .iUsrWriteValid(iUsrWriteValid), .oUsrWriteReady(oUsrWriteReady),
        .oOpcode(oOpcode), .oTargetID(oTargetID), .oSourceID(oSourceID), .oAddress(oAddress),
        .oLength(oLength), .oCMDValid(oCMDValid), .iCMDReady(iCMDReady),
        .oWriteData(oWriteData), .oWriteKeep(oWriteKeep), .oWriteLast(oWriteLast),
        .oWriteValid(oWriteValid), .iWriteReady(iWriteReady),
        .iReadData(iReadData), .iReadValid(iReadValid), .iReadLast(iReadLast), .oReadReady(oReadReady)
    );

    always #5 iSystemClock = ~iSystemClock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge iSystemClock) cyc <= cyc + 1;

    logic [63:0] w_cmd;
    assign w_cmd = {oOpcode, oTargetID, oSourceID, oAddress, oLength};

    logic [63:0] cmd_q[$];
    logic [18:0] wr_q[$];
    logic [7:0]  st_list[$];
    bit          bp = 1'b0;
    int          stall_until = 0;
    int          req_id = 0;
    int          stat_cmds = 0;
    int          stat_served = 0;
    int          rd_end_t = 0;
    int          rd_end_req = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rst_chk(input string tag);
        chk(tag, 64'({oReqReady, oCMDValid, oRspValid, oRspFail, oRspTimeout, oRspStatus,
                      oReadReady, oUsrWriteReady, oWriteValid}), 64'({1'b1, 15'd0}));
        chk(tag, w_cmd, 64'd0);
    endtask

    // Controller command port: random stalls, logging, hold-stability and poll-gap checks.
    logic [63:0] hold_v;
    bit          hold = 1'b0;
    always @(negedge iSystemClock) begin
        iCMDReady = (cyc < stall_until) ? 1'b0 : (bp ? ($urandom_range(0, 2) != 0) : 1'b1);
        #1;
        if (iReset) hold = 1'b0;
        else begin
            if (hold) begin
                chk("cmd_hold_v", 64'(oCMDValid), 64'd1);
                chk("cmd_hold_f", w_cmd, hold_v);
            end
            hold   = oCMDValid && !iCMDReady;
            hold_v = w_cmd;
            if (oCMDValid && iCMDReady) begin
                cmd_q.push_back(w_cmd);
                if (oOpcode == 6'h07) begin
                    stat_cmds++;
                    if (rd_end_req == req_id) chk("poll_gap", 64'(cyc - rd_end_t > PG), 64'd1);
                end
            end
        end
    end

    // Controller write port sink.
    always @(negedge iSystemClock) begin
        iWriteReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (!iReset && oWriteValid && iWriteReady) wr_q.push_back({oWriteLast, oWriteKeep, oWriteData});
    end

    // Status read responder; junk beats are offered while no status read is due.
    int         rd_req = 0;
    int         src_idx = 0;
    int         rd_n = 0;
    int         rd_i = 0;
    bit         rd_act = 1'b0;
    logic [7:0] rd_b;
    always @(negedge iSystemClock) begin
        if (req_id != rd_req) begin rd_req = req_id; src_idx = 0; end
        if (!rd_act && stat_cmds > stat_served) begin
            stat_served++;
            rd_b = (src_idx < st_list.size()) ? st_list[src_idx] : 8'h00;
            src_idx++;
            rd_n   = $urandom_range(1, 3);
            rd_i   = 0;
            rd_act = 1'b1;
        end
        if (rd_act) begin
            iReadValid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            iReadData  = (rd_i == 0) ? {8'($urandom), rd_b} : 16'($urandom);
            iReadLast  = (rd_i == rd_n - 1);
        end else begin
            iReadValid = 1'($urandom_range(0, 1));
            iReadData  = 16'($urandom);
            iReadLast  = 1'($urandom_range(0, 1));
        end
        #1;
        if (iReset) begin
            rd_act      = 1'b0;
            stat_served = stat_cmds;
        end else if (rd_act) begin
            if (iReadValid && oReadReady) begin
                rd_i++;
                if (rd_i == rd_n) begin rd_act = 1'b0; rd_end_t = cyc; rd_end_req = req_id; end
            end
        end else if (iReadValid) chk("rd_ready_idle", 64'(oReadReady), 64'd0);
    end

    // One full request against the model built from st_list.
    task automatic do_req(input logic [1:0] way, input logic [23:0] row, input logic [15:0] len,
                          input bit cache, input int nb, input logic [15:0] dbase, input int rsp_dly);
        logic [63:0] exp_c[$];
        logic [18:0] exp_w[$];
        logic [7:0]  st, es;
        logic        ef, eto, l;
        logic [15:0] d;
        logic [1:0]  k;
        int          c0, w0, g;
        ef = 1'b0; eto = 1'b0; es = 8'h00;
        exp_c.push_back({6'h20, 5'd0, 5'd0, 32'(way), 16'd8});
        exp_c.push_back({6'h24, 5'd0, 5'd0, 8'd0, row, 16'd8});
        exp_c.push_back({6'h03, cache ? 5'd1 : 5'd0, 5'd0, 32'd0, len});
        for (int p = 1; p <= MP; p++) begin
            st = (p <= st_list.size()) ? st_list[p-1] : 8'h00;
            exp_c.push_back({6'h07, 5'd4, 5'd0, 32'd0, 16'd8});
            if (cache ? st[6] : st[5]) begin ef = st[0]; eto = 1'b0; es = st; break; end
            if (p == MP) begin ef = 1'b0; eto = 1'b1; es = st; end
        end
        c0 = cmd_q.size();
        w0 = wr_q.size();

        @(negedge iSystemClock);
        req_id++;
        if (bp) stall_until = cyc + 5;
        iReqValid = 1'b1; iReqWay = way; iReqRow = row; iReqLength = len; iReqCache = cache;
        #1; g = 0;
        while (!oReqReady && g < 100) begin @(negedge iSystemClock); #1; g++; end
        chk("req_accept", 64'(oReqReady), 64'd1);
        @(negedge iSystemClock);
        iReqValid = 1'b0;

        for (int i = 0; i < nb; i++) begin
            if (bp && $urandom_range(0, 2) == 0) begin iUsrWriteValid = 1'b0; @(negedge iSystemClock); end
            d = dbase + {8'(2*i+1), 8'(2*i+2)};
            l = (i == nb - 1);
            k = l ? 2'($urandom_range(1, 3)) : 2'b11;
            iUsrWriteValid = 1'b1; iUsrWriteData = d; iUsrWriteKeep = k; iUsrWriteLast = l;
            exp_w.push_back({l, k, d});
            #1; g = 0;
            while (!oUsrWriteReady && g < 500) begin @(negedge iSystemClock); #1; g++; end
            chk("wr_handshake", 64'(oUsrWriteReady), 64'd1);
            @(negedge iSystemClock);
        end
        iUsrWriteValid = 1'b0; iUsrWriteLast = 1'b0;

        #1; g = 0;
        while (!oRspValid && g < 2000) begin @(negedge iSystemClock); #1; g++; end
        chk("rsp_seen", 64'(oRspValid), 64'd1);
        for (int i = 0; i < rsp_dly; i++) begin
            @(negedge iSystemClock); iRspReady = 1'b0; #1;
            chk("rsp_hold", 64'({oRspValid, oRspFail, oRspTimeout, oRspStatus}), 64'({1'b1, ef, eto, es}));
        end
        @(negedge iSystemClock); iRspReady = 1'b1; #1;
        chk("rsp_fields", 64'({oRspValid, oRspFail, oRspTimeout, oRspStatus}), 64'({1'b1, ef, eto, es}));
        @(negedge iSystemClock); iRspReady = 1'b0; #1;
        chk("rsp_single", 64'(oRspValid), 64'd0);
        chk("idle_ready", 64'(oReqReady), 64'd1);

        chk("cmd_count", 64'(cmd_q.size() - c0), 64'(exp_c.size()));
        foreach (exp_c[i]) if (c0 + i < cmd_q.size()) chk("cmd", cmd_q[c0+i], exp_c[i]);
        chk("wr_count", 64'(wr_q.size() - w0), 64'(exp_w.size()));
        foreach (exp_w[i]) if (w0 + i < wr_q.size()) chk("wr_beat", 64'(wr_q[w0+i]), 64'(exp_w[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required test end");
        $fatal;
    end

    initial begin
        int g;
        iReset = 1'b1; iReqValid = 1'b0; iReqWay = '0; iReqRow = '0; iReqLength = '0; iReqCache = 1'b0;
        iRspReady = 1'b0; iUsrWriteData = '0; iUsrWriteKeep = '0; iUsrWriteLast = 1'b0; iUsrWriteValid = 1'b0;
        repeat (3) @(negedge iSystemClock);
        #1;
        rst_chk("reset_state");
        @(negedge iSystemClock);
        iReset = 1'b0;

        // Plain program, three polls, done on ARDY.
        bp = 1'b0;
        st_list = '{8'h00, 8'h00, 8'h60};
        do_req(2'b10, 24'h000003, 16'd8, 1'b0, 4, 16'h0000, 0);
        // Cache program: 0x20 is not RDY, 0x40 is.
        st_list = '{8'h20, 8'h40};
        do_req(2'b01, 24'h000001, 16'd8, 1'b1, 3, 16'h1000, 0);
        // Plain program that ends with fail bit set.
        st_list = '{8'h61};
        do_req(2'b01, 24'h00ABCD, 16'd16, 1'b0, 2, 16'h2000, 1);
        // Never ready: timeout after MaxPolls status reads.
        st_list = '{8'h00, 8'h00, 8'h00};
        do_req(2'b10, 24'h123456, 16'd4, 1'b0, 1, 16'h3000, 0);
        // Backpressure on command, write and response channels.
        bp = 1'b1;
        st_list = '{8'h00, 8'h20};
        do_req(2'b01, 24'hFFFFFF, 16'd8, 1'b0, 5, 16'h4000, 4);
        bp = 1'b0;

        // Reset in the middle of WDATA.
        st_list = '{8'h60};
        @(negedge iSystemClock);
        req_id++;
        iReqValid = 1'b1; iReqWay = 2'b01; iReqRow = 24'h5; iReqLength = 16'd8; iReqCache = 1'b0;
        #1; g = 0;
        while (!oReqReady && g < 100) begin @(negedge iSystemClock); #1; g++; end
        @(negedge iSystemClock);
        iReqValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iUsrWriteValid = 1'b1; iUsrWriteData = 16'(i); iUsrWriteKeep = 2'b11; iUsrWriteLast = 1'b0;
            #1; g = 0;
            while (!oUsrWriteReady && g < 100) begin @(negedge iSystemClock); #1; g++; end
            chk("rst_wr_hs", 64'(oUsrWriteReady), 64'd1);
            @(negedge iSystemClock);
        end
        iUsrWriteValid = 1'b0;
        iReset = 1'b1;
        @(negedge iSystemClock); #1;
        rst_chk("rst_mid_wdata");
        @(negedge iSystemClock);
        iReset = 1'b0;

        // Reset while a command is pending drops oCMDValid at once.
        stall_until = cyc + 1000;
        req_id++;
        iReqValid = 1'b1; iReqWay = 2'b10; iReqRow = 24'h7; iReqLength = 16'd8; iReqCache = 1'b1;
        #1; g = 0;
        while (!oReqReady && g < 100) begin @(negedge iSystemClock); #1; g++; end
        @(negedge iSystemClock);
        iReqValid = 1'b0;
        #1;
        chk("cmd_pending", 64'(oCMDValid), 64'd1);
        @(negedge iSystemClock);
        iReset = 1'b1; #1;
        chk("rst_drop_cmdv", 64'(oCMDValid), 64'd0);
        @(negedge iSystemClock); #1;
        rst_chk("rst_mid_cmd");
        @(negedge iSystemClock);
        iReset = 1'b0;
        stall_until = 0;

        // Normal request after reset.
        st_list = '{8'h60};
        do_req(2'b01, 24'h000042, 16'd8, 1'b0, 4, 16'h5000, 0);

        // Randomized requests.
        for (int r = 0; r < 8; r++) begin
            bp = 1'($urandom_range(0, 1));
            st_list = {};
            for (int j = 0; j < 3; j++) st_list.push_back(8'($urandom));
            do_req(2'(1 << $urandom_range(0, 1)), 24'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   $urandom_range(1, 6), 16'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nfc_page_program_sequencer.md
Name: nfc_page_program_sequencer

Overview:
- Hardware front-end that sits directly upstream of the NAND flash controller top-level command/data interface.
- Turns one user "program page" request into the full controller command sequence: select way, set row address, program (plain or cache), stream page data, then poll read-status (70h) until ready.
- Returns a single pass/fail/timeout response per request, replacing the software polling loop.

Parameters:
- NumberOfWays, 2, number of NAND ways; width of the way-select mask.
- PollGap, 16, idle cycles between a status result and the next status command (range 1..65535).
- MaxPolls, 1024, status reads allowed before the request is aborted with timeout (range 1..65535).

Ports:
- iSystemClock  in  1  system clock, 100 MHz.
- iReset  in  1  synchronous active-high reset.
- iReqValid  in  1  request valid.
- oReqReady  out  1  request ready; high only in IDLE.
- iReqWay  in  NumberOfWays  one-hot way mask.
- iReqRow  in  24  row address.
- iReqLength  in  16  page data length field.
- iReqCache  in  1  1 = cache program (80h-15h), 0 = program (80h-10h).
- oRspValid / iRspReady  out/in  1/1  response handshake.
- oRspFail  out  1  status bit0 of the final status byte.
- oRspTimeout  out  1  MaxPolls exhausted.
- oRspStatus  out  8  final status byte.
- iUsrWriteData / iUsrWriteKeep / iUsrWriteLast / iUsrWriteValid / oUsrWriteReady  in/in/in/in/out  16/2/1/1/1  user page-data stream.
- oOpcode / oTargetID / oSourceID / oAddress / oLength  out  6/5/5/32/16  controller command fields.
- oCMDValid / iCMDReady  out/in  1/1  controller command handshake.
- oWriteData / oWriteKeep / oWriteLast / oWriteValid / iWriteReady  out/out/out/out/in  16/2/1/1/1  controller write stream.
- iReadData / iReadValid / iReadLast / oReadReady  in/in/in/out  16/1/1/1  controller read stream.

Behaviour:
- Reset: state IDLE; oReqReady=1; oCMDValid=0; oRspValid=0; oRspFail=0; oRspTimeout=0; oRspStatus=0; oOpcode=0; oTargetID=0; oSourceID=0; oAddress=0; oLength=0; oReadReady=0; poll counter=0; gap counter=0. Reset mid-sequence drops oCMDValid the same cycle and abandons the request; no response is produced.
- Request accept: iReqValid&oReqReady. All request fields are latched.
- A command transfers on the edge where oCMDValid&iCMDReady. oCMDValid stays high and fields stay stable until the transfer.
- Command fields per state. oSourceID is always 0.
  - WAY: opcode 6'b100000, target 0, address {zeros, iReqWay}, length 8.
  - ROW: opcode 6'b100100, target 0, address {8'd0, row}, length 8.
  - PROG: opcode 6'b000011, target 5'b00001 if cache else 5'b00000, address 0, length = latched length.
  - STAT_CMD: opcode 6'b000111, target 5'b00100, address 0, length 8.
- WDATA: combinational pass-through of the user stream to the controller stream (oWriteValid=iUsrWriteValid&inWDATA, oUsrWriteReady=iWriteReady&inWDATA). Outside WDATA both valids and readies are 0. The state exits on a handshake with iUsrWriteLast=1.
- STAT_RD: oReadReady=1. The first beat's iReadData[7:0] is captured as the status byte. Remaining beats are drained until iReadLast. A single beat with last=1 is legal.
- EVAL: done when status bit6 (RDY)=1 for cache programs, or status bit5 (ARDY)=1 for plain programs.
  - Done -> RESP with fail=bit0.
  - Not done and polls==MaxPolls -> RESP with timeout=1, fail=0.
  - Otherwise -> GAP for PollGap cycles, then STAT_CMD.
- Poll counter: 16-bit, cleared on request accept, incremented once per captured status byte, saturates.
- State sequence: IDLE -> WAY -> ROW -> PROG -> WDATA -> STAT_CMD -> STAT_RD -> EVAL -> (GAP -> STAT_CMD)* -> RESP -> IDLE.
- RESP: oRspValid held with stable fields until iRspReady; returns to IDLE the cycle after the handshake.
- Back-to-back: a new request can be accepted the cycle after the response handshake.
- Read beats arriving outside STAT_RD are not accepted (oReadReady=0).

Test Plan:
- Plain program, way 1, row 0x000003, length 8, 4 data beats 0x0102..0x0708; status replies 0x00, 0x00, then 0x60 -> commands in order 0x20, 0x24, 0x03 (target 0), three 0x07 (target 4); 4 write beats with last on 0x0708; response fail=0, timeout=0, status=0x60.
- Cache program, row 0x000001; status replies 0x20 then 0x40 -> first reply not done (RDY=0); second done; PROG target=1; response status=0x40.
- Plain program with final status 0x61 -> oRspFail=1.
- MaxPolls=3, status always 0x00 -> exactly 3 status commands; response timeout=1; GAP is at least PollGap cycles between status result and next command.
- Backpressure: iCMDReady low 5 cycles, iWriteReady toggling, iRspReady delayed 4 cycles -> fields stable, no lost or duplicated beats, single response.
- iReset asserted during WDATA -> next cycle all outputs at reset values; a new request then completes normally.
